pry2oht_scan: RTL and testbench
===============================

# pry2oht_scan

Sequential scanner that accepts a request vector over a valid/ready handshake and emits its set bits one per transfer, lowest index first. Each grant is a one-hot vector plus its binary index. It sits directly downstream of the priority-to-one-hot tree: it holds the residual vector in a register, uses `pry2oht_tree` to select the next grant, and clears each granted bit on every accepted output transfer. Typical uses are serializing interrupt or request masks, and walking set bits of a mask for a DMA or scatter unit.

## Interface
- `WIDTH`, default 32: request vector width; must be a power of `SPLIT`.
- `SPLIT`, default 2: tree split factor, passed to `pry2oht_tree`.
- `IMPLEMENTATION`, default 0: passed to `pry2oht_tree`.
- `WIDTH_LOG`, localparam `$clog2(WIDTH)`: index width.
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `i_vld`, input, 1: input vector valid.
- `i_rdy`, output, 1: input vector ready.
- `i_pry`, input, WIDTH: request vector; bit 0 has highest priority.
- `o_vld`, output, 1: grant valid.
- `o_rdy`, input, 1: grant ready.
- `o_oht`, output, WIDTH: one-hot grant.
- `o_idx`, output, WIDTH_LOG: binary index of the set bit in `o_oht`.
- `o_lst`, output, 1: this grant is the last set bit of the loaded vector.

## Operation
- State register `sts` has 2 states: IDLE and SCAN.
- Residual register `rsd` is WIDTH bits and holds the bits not yet granted.
- Combinational path: `pry2oht_tree(rsd)` drives `o_oht`.
  - `o_idx` is the one-hot-to-binary OR-encode of `o_oht`.
  - `o_lst = ~|(rsd & ~o_oht)`.
  - `o_vld = (sts == SCAN)`.
- Input transfer: `i_vld & i_rdy`.
- Output transfer: `o_vld & o_rdy`.
- `i_rdy = (sts == IDLE) | (o_vld & o_rdy & o_lst)`. This allows back-to-back vectors with no bubble.
- IDLE:
  - Input transfer with `i_pry != 0`: `rsd <= i_pry`, go to SCAN.
  - Input transfer with `i_pry == 0`: vector is consumed and discarded. Stay in IDLE, `rsd` stays 0, no grant is produced.
- SCAN, output transfer with `o_lst == 0`: `rsd <= rsd & ~o_oht`, stay in SCAN.
- SCAN, output transfer with `o_lst == 1`:
  - With a simultaneous input transfer of a nonzero vector: `rsd <= i_pry`, stay in SCAN. The load overrides the clear.
  - With a simultaneous input transfer of a zero vector, or with no input transfer: `rsd <= 0`, go to IDLE.
- SCAN without an output transfer: `rsd` and all outputs hold. `o_oht`, `o_idx` and `o_lst` must remain stable while `o_vld & ~o_rdy`.
- Invariants:
  - In IDLE, `rsd == 0`, which forces `o_oht == 0`, `o_idx == 0` and `o_lst == 1`. `o_lst` is only meaningful when `o_vld` is high.
  - In SCAN, `rsd != 0`.
  - `o_oht` is always zero or one-hot.
- Number of grants for a vector equals `$countones(i_pry)`. Grants appear in strictly increasing index order.

## Timing
- Reset (`rst_n` low, asynchronous): `sts` = IDLE and `rsd` = 0.
  - Hence `o_vld` = 0, `o_oht` = 0, `o_idx` = 0, `o_lst` = 1, `i_rdy` = 1.
  - Transfers while `rst_n` is low have no effect.
- Reset asserted mid-scan: remaining bits are lost immediately and `o_vld` drops asynchronously. After release, the first edge behaves as IDLE.
- Latency: a vector accepted on edge N gives its first grant with `o_vld` high after edge N, i.e. one cycle.
- Throughput: one grant per cycle while `o_rdy` is held high.
- A vector with k set bits occupies exactly k cycles when `o_rdy` is held high. The next vector's first grant follows with no idle cycle if `i_vld` is high on the last transfer.
- Combinational paths exist from `o_rdy` to `i_rdy`, and from `rsd` through `pry2oht_tree` and the encoder to the outputs. There is no path from `i_pry` to any output.

## Test plan
1. Reset, then load `i_pry = 32'h8000_0015` with `o_rdy = 1` -> grants, one per cycle:
   - idx 0, oht `32'h1`, lst 0
   - idx 2, oht `32'h4`, lst 0
   - idx 4, oht `32'h10`, lst 0
   - idx 31, oht `32'h8000_0000`, lst 1
   - then `o_vld = 0` and `i_rdy = 1`.
2. Load `32'h0000_0006`, hold `o_rdy = 0` for 3 cycles -> `o_vld = 1`, `o_idx = 1` and `o_oht = 32'h2` stay stable with `i_rdy = 0`. Then assert `o_rdy` -> idx 1, then idx 2 with lst 1.
3. Load `32'h3`, then `32'h10` presented with `i_vld` high throughout and `o_rdy = 1` -> idx 0, idx 1 (lst), idx 4 (lst) on consecutive cycles with no bubble. `i_rdy` pulses on the idx 1 cycle.
4. Load `32'h0` -> accepted in one cycle, `o_vld` stays 0. Then load `32'hFFFF_FFFF` -> 32 grants, idx 0..31, lst only on idx 31.
5. Load `32'hF0`, accept one grant (idx 4), assert `rst_n = 0` mid-cycle -> `o_vld` falls immediately. After release, `i_rdy = 1`, `o_vld = 0`, and no stale grants appear.
6. Random vectors with random `o_rdy`/`i_vld` stalls, run with `SPLIT = 2` and `SPLIT = 4` -> each vector's grant sequence equals its set bits in ascending order, with `o_oht == 1 << o_idx` on every transfer.

Source files
------------

// File: rtl/pry2oht_scan_if.sv
// Request/grant bus of the set-bit scanner: vector in over valid/ready, one-hot grants out.
// slave is the scanner's view; master is the producer/consumer side that drives it.
interface pry2oht_scan_if #(
  parameter int WIDTH     = 32,
  parameter int WIDTH_LOG = $clog2(WIDTH)
);
  logic                 i_vld;
  logic                 i_rdy;
  logic [WIDTH-1:0]     i_pry;
  logic                 o_vld;
  logic                 o_rdy;
  logic [WIDTH-1:0]     o_oht;
  logic [WIDTH_LOG-1:0] o_idx;
  logic                 o_lst;

  modport slave (
    input  i_vld, i_pry, o_rdy,
    output i_rdy, o_vld, o_oht, o_idx, o_lst
  );

  modport master (
    output i_vld, i_pry, o_rdy,
    input  i_rdy, o_vld, o_oht, o_idx, o_lst
  );
endinterface

// File: rtl/pry2oht_scan.sv
// Serializes a request vector into one-hot grants, lowest index first; first grant 1 cycle after load.
// Holds grants stable under o_rdy low; next vector is accepted on the last grant's transfer (no bubble).
module pry2oht_tree #(
  parameter int WIDTH          = 32,
  parameter int SPLIT          = 2,
  parameter int IMPLEMENTATION = 0
) (
  input  logic [WIDTH-1:0] pry,
  output logic [WIDTH-1:0] oht
);
  localparam int SUB = (WIDTH > SPLIT) ? WIDTH / SPLIT : 1;

  if (WIDTH <= SPLIT) begin : g_leaf
    if (IMPLEMENTATION == 0) begin : g_loop
      always_comb begin
        logic found;
        found = 1'b0;
        oht   = '0;
        for (int i = 0; i < WIDTH; i++) begin
          if (pry[i] && !found) begin
            oht[i] = 1'b1;
            found  = 1'b1;
          end
        end
      end
    end else begin : g_arith
      // Two's complement isolates the lowest set bit.
      assign oht = pry & (~pry + WIDTH'(1));
    end
  end else begin : g_node
    logic [SPLIT-1:0] grp_any;
    logic [SPLIT-1:0] grp_sel;
    logic [WIDTH-1:0] sub_oht;

    for (genvar g = 0; g < SPLIT; g++) begin : g_sub
      pry2oht_tree #(
        .WIDTH          (SUB),
        .SPLIT          (SPLIT),
        .IMPLEMENTATION (IMPLEMENTATION)
      ) u_sub (
        .pry (pry[g*SUB +: SUB]),
        .oht (sub_oht[g*SUB +: SUB])
      );
      assign grp_any[g]         = |pry[g*SUB +: SUB];
      assign oht[g*SUB +: SUB]  = sub_oht[g*SUB +: SUB] & {SUB{grp_sel[g]}};
    end

    // The lowest non-empty group wins; only its local grant passes through.
    pry2oht_tree #(
      .WIDTH          (SPLIT),
      .SPLIT          (SPLIT),
      .IMPLEMENTATION (IMPLEMENTATION)
    ) u_grp (
      .pry (grp_any),
      .oht (grp_sel)
    );
  end
endmodule

module pry2oht_scan #(
  parameter int WIDTH          = 32,
  parameter int SPLIT          = 2,
  parameter int IMPLEMENTATION = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pry2oht_scan_if.slave         bus
);
  localparam int WIDTH_LOG = $clog2(WIDTH);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } sts_t;

  sts_t                 sts_q, sts_d;
  logic [WIDTH-1:0]     rsd_q, rsd_d;
  logic [WIDTH-1:0]     oht;
  logic [WIDTH_LOG-1:0] idx;
  logic                 lst;
  logic                 o_vld;
  logic                 o_xfer;
  logic                 i_rdy;

  pry2oht_tree #(
    .WIDTH          (WIDTH),
    .SPLIT          (SPLIT),
    .IMPLEMENTATION (IMPLEMENTATION)
  ) u_tree (
    .pry (rsd_q),
    .oht (oht)
  );

  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (oht[i]) idx = idx | WIDTH_LOG'(i);
    end
  end

  assign lst    = ~|(rsd_q & ~oht);
  assign o_vld  = (sts_q == SCAN);
  assign o_xfer = o_vld & bus.o_rdy;
  assign i_rdy  = (sts_q == IDLE) | (o_xfer & lst);

  assign bus.o_vld = o_vld;
  assign bus.o_oht = oht;
  assign bus.o_idx = idx;
  assign bus.o_lst = lst;
  assign bus.i_rdy = i_rdy;

  always_comb begin
    sts_d = sts_q;
    rsd_d = rsd_q;
    case (sts_q)
      IDLE: begin
        // An all-zero vector is consumed without producing any grant.
        if (bus.i_vld && (|bus.i_pry)) begin
          rsd_d = bus.i_pry;
          sts_d = SCAN;
        end
      end
      SCAN: begin
        if (o_xfer) begin
          if (!lst) begin
            rsd_d = rsd_q & ~oht;
          end else if (bus.i_vld && (|bus.i_pry)) begin
            rsd_d = bus.i_pry;
          end else begin
            rsd_d = '0;
            sts_d = IDLE;
          end
        end
      end
      default: begin
        sts_d = IDLE;
        rsd_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sts_q <= IDLE;
      rsd_q <= '0;
    end else begin
      sts_q <= sts_d;
      rsd_q <= rsd_d;
    end
  end
endmodule

// File: tb/tb_pry2oht_scan.sv
// Scoreboard bench: drivers push expected grants on acceptance, negedge monitors pop and compare.
// Instance a: WIDTH 32 / SPLIT 2; instance b: WIDTH 16 / SPLIT 4 with the arithmetic leaf.
module tb_pry2oht_scan;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pry2oht_scan_if #(.WIDTH(32)) bus_a ();
  pry2oht_scan_if #(.WIDTH(16)) bus_b ();

  pry2oht_scan #(.WIDTH(32), .SPLIT(2), .IMPLEMENTATION(0)) dut_a (
    .clk (clk), .rst_n (rst_n), .bus (bus_a)
  );
  pry2oht_scan #(.WIDTH(16), .SPLIT(4), .IMPLEMENTATION(1)) dut_b (
    .clk (clk), .rst_n (rst_n), .bus (bus_b)
  );

  typedef struct packed {
    logic [5:0] idx;
    logic       lst;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   checks = 0;
  int   errors = 0;
  bit   rnd_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_a(input int idx, input bit lst);
    exp_t e;
    e.idx = 6'(idx);
    e.lst = lst;
    q_a.push_back(e);
  endtask

  task automatic model_a(input logic [31:0] v);
    int left = $countones(v);
    for (int i = 0; i < 32; i++) begin
      if (v[i]) begin
        left--;
        push_a(i, left == 0);
      end
    end
  endtask

  task automatic model_b(input logic [15:0] v);
    int left = $countones(v);
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) begin
        left--;
        e.idx = 6'(i);
        e.lst = (left == 0);
        q_b.push_back(e);
      end
    end
  endtask

  // Entered and left at posedge+1; the vector is taken on the edge after a negedge with i_rdy high.
  task automatic send_a(input logic [31:0] v, input bit use_model);
    int n = 0;
    bus_a.i_vld = 1'b1;
    bus_a.i_pry = v;
    forever begin
      @(negedge clk);
      if (bus_a.i_rdy || n >= 200) break;
      n++;
    end
    if (n >= 200) begin
      chk("send_a_timeout", 32'(n), 32'd0);
    end else if (use_model) begin
      model_a(v);
    end
    @(posedge clk); #1;
    bus_a.i_vld = 1'b0;
  endtask

  task automatic send_b(input logic [15:0] v);
    int n = 0;
    bus_b.i_vld = 1'b1;
    bus_b.i_pry = v;
    forever begin
      @(negedge clk);
      if (bus_b.i_rdy || n >= 200) break;
      n++;
    end
    if (n >= 200) chk("send_b_timeout", 32'(n), 32'd0);
    else model_b(v);
    @(posedge clk); #1;
    bus_b.i_vld = 1'b0;
  endtask

  task automatic drain(input int lim);
    int n = 0;
    while ((q_a.size() != 0 || bus_a.o_vld || q_b.size() != 0 || bus_b.o_vld) && n < lim) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_timeout", 32'(n < lim), 32'd1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus_a.o_vld && bus_a.o_rdy) begin
      if (q_a.size() == 0) begin
        chk("a_unexpected_grant", {26'd0, bus_a.o_idx}, 32'hFFFF_FFFF);
      end else begin
        e = q_a.pop_front();
        chk("a_idx", {27'd0, bus_a.o_idx}, {26'd0, e.idx});
        chk("a_oht", bus_a.o_oht, 32'd1 << e.idx);
        chk("a_lst", {31'd0, bus_a.o_lst}, {31'd0, e.lst});
      end
    end
    if (rst_n && bus_b.o_vld && bus_b.o_rdy) begin
      if (q_b.size() == 0) begin
        chk("b_unexpected_grant", {28'd0, bus_b.o_idx}, 32'hFFFF_FFFF);
      end else begin
        e = q_b.pop_front();
        chk("b_idx", {28'd0, bus_b.o_idx}, {26'd0, e.idx});
        chk("b_oht", {16'd0, bus_b.o_oht}, 32'd1 << e.idx);
        chk("b_lst", {31'd0, bus_b.o_lst}, {31'd0, e.lst});
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_on) begin
      bus_a.o_rdy = ($urandom_range(0, 3) != 0);
      bus_b.o_rdy = ($urandom_range(0, 2) != 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    bus_a.i_vld = 1'b0; bus_a.i_pry = '0; bus_a.o_rdy = 1'b1;
    bus_b.i_vld = 1'b0; bus_b.i_pry = '0; bus_b.o_rdy = 1'b1;
    #12;
    chk("rst_o_vld", {31'd0, bus_a.o_vld}, 32'd0);
    chk("rst_i_rdy", {31'd0, bus_a.i_rdy}, 32'd1);
    chk("rst_o_oht", bus_a.o_oht, 32'd0);
    chk("rst_o_idx", {27'd0, bus_a.o_idx}, 32'd0);
    chk("rst_o_lst", {31'd0, bus_a.o_lst}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed: hand-computed grants for 8000_0015.
    push_a(0, 1'b0); push_a(2, 1'b0); push_a(4, 1'b0); push_a(31, 1'b1);
    send_a(32'h8000_0015, 1'b0);
    drain(50);
    chk("t1_o_vld_after", {31'd0, bus_a.o_vld}, 32'd0);
    chk("t1_i_rdy_after", {31'd0, bus_a.i_rdy}, 32'd1);

    // Stall: grant must hold while o_rdy is low.
    bus_a.o_rdy = 1'b0;
    push_a(1, 1'b0); push_a(2, 1'b1);
    send_a(32'h0000_0006, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("t2_hold_vld", {31'd0, bus_a.o_vld}, 32'd1);
      chk("t2_hold_idx", {27'd0, bus_a.o_idx}, 32'd1);
      chk("t2_hold_oht", bus_a.o_oht, 32'h2);
      chk("t2_hold_i_rdy", {31'd0, bus_a.i_rdy}, 32'd0);
    end
    @(posedge clk); #1;
    bus_a.o_rdy = 1'b1;
    drain(50);

    // Back-to-back vectors with no idle cycle.
    push_a(0, 1'b0); push_a(1, 1'b1); push_a(4, 1'b1);
    send_a(32'h0000_0003, 1'b0);
    chk("t3_i_rdy_mid", {31'd0, bus_a.i_rdy}, 32'd0);
    send_a(32'h0000_0010, 1'b0);
    chk("t3_nobubble_vld", {31'd0, bus_a.o_vld}, 32'd1);
    chk("t3_nobubble_idx", {27'd0, bus_a.o_idx}, 32'd4);
    drain(50);

    // Zero vector is swallowed; all-ones walks every index.
    send_a(32'h0, 1'b0);
    chk("t4_zero_vld", {31'd0, bus_a.o_vld}, 32'd0);
    chk("t4_zero_i_rdy", {31'd0, bus_a.i_rdy}, 32'd1);
    for (int i = 0; i < 32; i++) push_a(i, i == 31);
    send_a(32'hFFFF_FFFF, 1'b0);
    drain(100);

    // Reset in the middle of a scan.
    push_a(4, 1'b0);
    send_a(32'h0000_00F0, 1'b0);
    @(negedge clk);
    @(posedge clk); #2;
    chk("t5_pre_rst_idx", {27'd0, bus_a.o_idx}, 32'd5);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_o_vld", {31'd0, bus_a.o_vld}, 32'd0);
    chk("t5_rst_o_oht", bus_a.o_oht, 32'd0);
    q_a.delete();
    q_b.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_post_i_rdy", {31'd0, bus_a.i_rdy}, 32'd1);
    chk("t5_post_o_vld", {31'd0, bus_a.o_vld}, 32'd0);

    // Random vectors with stalls on both instances.
    rnd_on = 1'b1;
    fork
      begin
        logic [31:0] v;
        for (int k = 0; k < 30; k++) begin
          v = (k % 10 == 3) ? 32'h0 : 32'($urandom);
          if (k % 7 == 5) v = v & 32'h0101_0000;
          send_a(v, 1'b1);
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
      end
      begin
        logic [15:0] v;
        for (int k = 0; k < 30; k++) begin
          v = (k % 9 == 4) ? 16'h0 : 16'($urandom);
          send_b(v);
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
      end
    join
    rnd_on = 1'b0;
    @(posedge clk); #2;
    bus_a.o_rdy = 1'b1;
    bus_b.o_rdy = 1'b1;
    drain(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
